// File: rtl/sensor_pkg.sv
// Shared definitions for the level-sensor conditioning stage and the downstream
// sn0..snN decode blocks.
package sensor_pkg;

    localparam int unsigned N_SENSORS_DEFAULT    = 5;
    localparam int unsigned STABLE_TICKS_DEFAULT = 16;
    localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } filter_state_e;

    // Counter wide enough to hold 0..ticks without wrapping.
    function automatic int unsigned count_width(input int unsigned ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce_channel.sv
// One sensor channel: multi-flop input synchroniser followed by a debounce
// counter that accepts a new level after STABLE_TICKS qualifying sample ticks.
module sensor_debounce_channel
    import sensor_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic sample_en,
    input  logic run,
    output logic sync,
    output logic level,
    output logic update
);

    localparam int unsigned CW = count_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    always_comb begin
        sync = sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        update = 1'b0;
        if (run && (sync != level) && sample_en && (cnt == LAST)) begin
            update = 1'b1;
        end
    end

    // Outside RUN the level tracks the synchroniser directly and the counter
    // is parked at zero, so debouncing starts clean on entry to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (!run) begin
            level <= sync;
            cnt   <= '0;
        end else if (sync == level) begin
            cnt <= '0;
        end else if (sample_en) begin
            if (cnt == LAST) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sensor_debounce_filter.sv
// Sensor bank conditioning: per-channel synchronise/debounce, a power-up
// stability gate (INIT -> RUN) driving sn_valid, and a registered change strobe.
module sensor_debounce_filter
    import sensor_pkg::*;
#(
    parameter int unsigned N_SENSORS    = N_SENSORS_DEFAULT,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_SENSORS-1:0] sn_raw,
    input  logic                 sample_en,
    output logic [N_SENSORS-1:0] sn,
    output logic                 sn_valid,
    output logic                 sn_changed
);

    localparam int unsigned CW = count_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    filter_state_e        state;
    filter_state_e        state_next;
    logic [CW-1:0]        init_cnt;
    logic [CW-1:0]        init_cnt_next;
    logic                 valid_next;
    logic                 run;
    logic [N_SENSORS-1:0] sync;
    logic [N_SENSORS-1:0] update;

    always_comb begin
        run = (state == RUN);
    end

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_chan
        sensor_debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .raw      (sn_raw[i]),
            .sample_en(sample_en),
            .run      (run),
            .sync     (sync[i]),
            .level    (sn[i]),
            .update   (update[i])
        );
    end

    // In INIT every channel copies sync into sn each cycle, so sn is last
    // cycle's sync and (sync != sn) flags a change since the previous cycle.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        valid_next    = sn_valid;
        case (state)
            INIT: begin
                if (sync != sn) begin
                    init_cnt_next = '0;
                end else if (sample_en) begin
                    if (init_cnt == LAST) begin
                        state_next    = RUN;
                        valid_next    = 1'b1;
                        init_cnt_next = '0;
                    end else begin
                        init_cnt_next = init_cnt + CW'(1);
                    end
                end
            end
            RUN: begin
                valid_next = 1'b1;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            init_cnt   <= '0;
            sn_valid   <= 1'b0;
            sn_changed <= 1'b0;
        end else begin
            state      <= state_next;
            init_cnt   <= init_cnt_next;
            sn_valid   <= valid_next;
            sn_changed <= |update;
        end
    end

endmodule

// File: tb/tb_sensor_debounce_filter.sv
// Directed bench for sensor_debounce_filter with a tick-counting reference
// model checked every cycle plus hand-computed latency expectations.
module tb_sensor_debounce_filter;

    localparam int unsigned NS   = 5;
    localparam int unsigned ST   = 16;
    localparam int unsigned SYNC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] sn_raw;
    logic          sample_en;
    logic [NS-1:0] sn;
    logic          sn_valid;
    logic          sn_changed;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    sensor_debounce_filter #(
        .N_SENSORS   (NS),
        .STABLE_TICKS(ST),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sn_raw    (sn_raw),
        .sample_en (sample_en),
        .sn        (sn),
        .sn_valid  (sn_valid),
        .sn_changed(sn_changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: a raw sample becomes visible after SYNC edges; in RUN a
    // channel flips once it has seen ST sample ticks in an unbroken run of
    // disagreement with its current level; in INIT the bank goes valid after
    // ST ticks with no change since the previous cycle.
    bit [NS-1:0] m_q [SYNC];
    bit [NS-1:0] m_sn;
    bit          m_valid;
    bit          m_chg;
    bit          m_run;
    int          m_icnt;
    int          m_ticks [NS];
    bit          chk_on = 1'b0;

    always @(posedge clk) begin
        bit [NS-1:0] s;
        bit          any;
        s   = m_q[SYNC-1];
        any = 1'b0;
        if (reset) begin
            for (int k = 0; k < SYNC; k++) m_q[k] = '0;
            for (int i = 0; i < NS; i++) m_ticks[i] = 0;
            m_sn    = '0;
            m_valid = 1'b0;
            m_run   = 1'b0;
            m_icnt  = 0;
            chk_on  = 1'b1;
        end else begin
            for (int k = SYNC - 1; k > 0; k--) m_q[k] = m_q[k-1];
            m_q[0] = sn_raw;
            if (!m_run) begin
                if (s != m_sn) begin
                    m_icnt = 0;
                end else if (sample_en) begin
                    m_icnt++;
                    if (m_icnt == ST) begin
                        m_run   = 1'b1;
                        m_valid = 1'b1;
                        m_icnt  = 0;
                    end
                end
                m_sn = s;
            end else begin
                for (int i = 0; i < NS; i++) begin
                    if (s[i] == m_sn[i]) begin
                        m_ticks[i] = 0;
                    end else if (sample_en) begin
                        m_ticks[i]++;
                        if (m_ticks[i] == ST) begin
                            m_sn[i]    = s[i];
                            m_ticks[i] = 0;
                            any        = 1'b1;
                        end
                    end
                end
            end
        end
        m_chg = any;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_sn", 32'(sn), 32'(m_sn));
            check("model_sn_valid", 32'(sn_valid), 32'(m_valid));
            check("model_sn_changed", 32'(sn_changed), 32'(m_chg));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (sn_changed === 1'b1) pulses++;
    endtask

    int n;

    initial begin
        reset     = 1'b1;
        sn_raw    = 5'b11111;
        sample_en = 1'b1;
        repeat (3) tick();

        // 1: power-up stability gate
        reset  = 1'b0;
        pulses = 0;
        n      = 0;
        do begin
            tick();
            n++;
            if (n == 10) begin
                check("init_sn_follows", 32'(sn), 32'h1f);
                check("init_not_valid", 32'(sn_valid), 32'h0);
            end
        end while (sn_valid !== 1'b1 && n < 200);
        check("valid_latency", 32'(n), 32'd19);
        check("init_no_pulse", 32'(pulses), 32'd0);

        // 2: single channel fall in RUN
        sn_raw = 5'b11110;
        pulses = 0;
        n      = 0;
        do begin
            tick();
            n++;
        end while (sn[0] !== 1'b0 && n < 200);
        check("sn0_latency", 32'(n), 32'd18);
        check("sn0_value", 32'(sn), 32'h1e);
        check("sn0_pulse_on", 32'(sn_changed), 32'h1);
        tick();
        check("sn0_pulse_off", 32'(sn_changed), 32'h0);
        check("valid_held", 32'(sn_valid), 32'h1);

        // 3: bounce then restore, then a real change
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            sn_raw[2] = ~sn_raw[2];
            tick();
        end
        repeat (25) tick();
        check("bounce_sn", 32'(sn), 32'h1e);
        check("bounce_no_pulse", 32'(pulses), 32'd0);
        sn_raw[2] = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (sn[2] !== 1'b0 && n < 200);
        check("sn2_latency", 32'(n), 32'd18);

        // 4: sparse sample ticks, one edge in four
        tick();
        sn_raw[4] = 1'b0;
        n = 0;
        do begin
            n++;
            sample_en = ((n % 4) == 0);
            tick();
        end while (sn[4] !== 1'b0 && n < 400);
        sample_en = 1'b1;
        check("sn4_sparse_latency", 32'(n), 32'd64);
        check("sn4_value", 32'(sn), 32'h0a);

        // 5: simultaneous updates on two channels
        repeat (3) tick();
        pulses = 0;
        sn_raw = 5'b00000;
        n = 0;
        do begin
            tick();
            n++;
        end while (sn !== 5'b00000 && n < 200);
        check("dual_latency", 32'(n), 32'd18);
        repeat (5) tick();
        check("dual_single_pulse", 32'(pulses), 32'd1);

        // Reset lands on the edge that would have accepted the change
        sn_raw = 5'b11111;
        repeat (17) tick();
        check("pre_accept_sn", 32'(sn), 32'h00);
        reset = 1'b1;
        tick();
        check("reset_sn", 32'(sn), 32'h00);
        check("reset_valid", 32'(sn_valid), 32'h0);
        check("reset_pulse", 32'(sn_changed), 32'h0);
        reset = 1'b0;
        repeat (3) tick();
        check("reinit_follow", 32'(sn), 32'h1f);
        check("reinit_not_valid", 32'(sn_valid), 32'h0);
        repeat (25) tick();
        check("revalid", 32'(sn_valid), 32'h1);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
